// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind a UART receiver: done-strobed writes, valid/ready reads.
// Define UART_RX_FIFO_DROP_ERR_EN to discard bytes that arrive with a framing error.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              rx_error,
    input  logic              clear,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              overflow,
    output logic [7:0]        err_count
);

`ifdef UART_RX_FIFO_DROP_ERR_EN
    localparam bit DropErr = 1'b1;
`else
    localparam bit DropErr = 1'b0;
`endif

    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CountOne  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic rd_evt;
    logic store_req;
    logic at_full;
    logic wr_evt;
    logic mem_we;

    always_comb begin
        rd_evt    = out_ready && (count_q != '0);
        // Errored bytes never request storage when dropping is enabled.
        store_req = rx_done && !(DropErr && rx_error);
        at_full   = (count_q == FullCount);
        wr_evt    = store_req && (!at_full || rd_evt);
        mem_we    = wr_evt && !clear;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            err_cnt_d  = '0;
        end else begin
            if (wr_evt) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (rd_evt) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            case ({wr_evt, rd_evt})
                2'b10:   count_d = count_q + CountOne;
                2'b01:   count_d = count_q - CountOne;
                default: count_d = count_q;
            endcase
            if (store_req && at_full && !rd_evt) begin
                overflow_d = 1'b1;
            end
            if (rx_done && rx_error && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign level     = count_q;
    assign full      = at_full;
    assign overflow  = overflow_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_error;
    logic       clear;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] level;
    logic       full;
    logic       overflow;
    logic [7:0] err_count;

    int n_pass  = 0;
    int n_total = 0;

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_error  (rx_error),
        .clear     (clear),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .overflow  (overflow),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic err);
        rx_data  = b;
        rx_error = err;
        rx_done  = 1'b1;
        tick();
        rx_done  = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        int         written;
        int         n;
        logic [7:0] v;

        reset_n   = 1'b0;
        rx_data   = 8'h00;
        rx_done   = 1'b0;
        rx_error  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("por");
        reset_n = 1'b1;
        tick();

        // Single byte through the FIFO.
        write_byte(8'hA5, 1'b0);
        check("a5_valid", 32'(out_valid), 32'd1);
        check("a5_data", 32'(out_data), 32'hA5);
        check("a5_level", 32'(level), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("a5_drained_valid", 32'(out_valid), 32'd0);
        check("a5_drained_level", 32'(level), 32'd0);

        // Fill to full, then overflow with 0x55.
        for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'd16);
        check("fill_ovf", 32'(overflow), 32'd0);
        write_byte(8'h55, 1'b0);
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_level", 32'(level), 32'd16);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_%0d", i), 32'(out_data), 32'(i));
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_ovf_sticky", 32'(overflow), 32'd1);
        do_clear();
        check("clr_ovf", 32'(overflow), 32'd0);

        // Write while full with a simultaneous read is accepted.
        for (int i = 0; i < 16; i++) write_byte(8'(8'h20 + i), 1'b0);
        rx_data   = 8'h77;
        rx_done   = 1'b1;
        out_ready = 1'b1;
        tick();
        rx_done = 1'b0;
        check("rw_full_level", 32'(level), 32'd16);
        check("rw_full_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("rw_drain_%0d", i), 32'(out_data), 32'(8'h20 + i));
            tick();
        end
        check("rw_last", 32'(out_data), 32'h77);
        tick();
        out_ready = 1'b0;
        check("rw_empty", 32'(out_valid), 32'd0);

        // Framing error accounting.
        write_byte(8'h3C, 1'b1);
        check("err_cnt1", 32'(err_count), 32'd1);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        check("err_level", 32'(level), 32'd0);
`else
        check("err_level", 32'(level), 32'd1);
        check("err_data", 32'(out_data), 32'h3C);
`endif
        do_clear();
        check("err_clr", 32'(err_count), 32'd0);
        for (int i = 0; i < 254; i++) write_byte(8'(i), 1'b1);
        check("err_254", 32'(err_count), 32'd254);
        for (int i = 0; i < 46; i++) write_byte(8'(i), 1'b1);
        check("err_sat", 32'(err_count), 32'd255);
        do_clear();

        // Clear wins over a concurrent write.
        for (int i = 0; i < 5; i++) write_byte(8'(8'h40 + i), 1'b0);
        check("pre_clr_level", 32'(level), 32'd5);
        rx_data  = 8'h11;
        rx_done  = 1'b1;
        rx_error = 1'b1;
        clear    = 1'b1;
        tick();
        rx_done  = 1'b0;
        rx_error = 1'b0;
        clear    = 1'b0;
        check("clr_level", 32'(level), 32'd0);
        check("clr_ovf2", 32'(overflow), 32'd0);
        check("clr_err", 32'(err_count), 32'd0);
        check("clr_valid", 32'(out_valid), 32'd0);

        // Wrap-around with a mid-sequence asynchronous reset.
        written = 0;
        for (int g = 0; g < 14; g++) begin
            n = (40 - written < 3) ? 40 - written : 3;
            for (int j = 0; j < n; j++) begin
                v = 8'(written * 7 + 3);
                write_byte(v, 1'b0);
                q.push_back(v);
                written++;
            end
            if (g == 7) begin
                reset_n = 1'b0;
                tick();
                check_reset_outputs("mid_rst");
                q.delete();
                reset_n = 1'b1;
                tick();
            end
            out_ready = 1'b1;
            while (q.size() > 0) begin
                check($sformatf("wrap_g%0d", g), 32'(out_data), 32'(q[0]));
                tick();
                void'(q.pop_front());
            end
            out_ready = 1'b0;
            check($sformatf("wrap_empty_g%0d", g), 32'(out_valid), 32'd0);
        end
        write_byte(8'h99, 1'b0);
        check("post_rst_data", 32'(out_data), 32'h99);
        check("post_rst_level", 32'(level), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_rst_empty", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. Captures each completed byte (strobed by the receiver's one-cycle done pulse) into a circular FIFO and presents it to the consuming logic over a valid/ready stream. Overflow, fill level and framing-error accounting are exposed so software or a command parser can drain the UART at its own pace without losing bytes silently.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..256
- ADDR_W, 4, log2(DEPTH); must match DEPTH
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte, valid when rx_done=1
- rx_done  in  1  one-cycle write strobe from receiver
- rx_error  in  1  stop-bit error flag, qualified by rx_done
- clear  in  1  synchronous flush, active-high
- out_data  out  8  head-of-FIFO byte, valid when out_valid=1
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head byte when out_valid & out_ready
- level  out  ADDR_W+1  current number of stored bytes, 0..DEPTH
- full  out  1  level == DEPTH
- overflow  out  1  sticky; set when a byte is dropped for lack of space
- err_count  out  8  framing errors seen, saturates at 255

## Operation
- Storage: DEPTH x 8 array, write pointer wr_ptr and read pointer rd_ptr (ADDR_W bits, wrap modulo DEPTH), registered count.
- Write event: rx_done=1 and byte accepted (see below) -> mem[wr_ptr]<=rx_data, wr_ptr+1.
- Read event: out_valid & out_ready -> rd_ptr+1.
- Acceptance: write accepted when count<DEPTH, or when count==DEPTH and a read event occurs in the same cycle (count unchanged).
- Write attempted at count==DEPTH with no read -> byte dropped, pointers unchanged, overflow<=1.
- Count: +1 on write only, -1 on read only, unchanged on both or neither.
- Read at count==0 impossible (out_valid=0); out_ready ignored when empty.
- rx_done with rx_error=1: err_count increments (saturating at 255) regardless of whether the byte is stored; storage policy per Configuration.
- clear=1: wr_ptr, rd_ptr, count <=0; overflow<=0; err_count<=0. Clear has priority over any write/read in the same cycle; that cycle's rx_done byte is discarded and not counted.
- overflow stays set until clear or reset.
- Reset (reset_n=0, any time incl. mid-burst): pointers 0, count 0, overflow 0, err_count 0; outputs out_valid=0, full=0, level=0, overflow=0, err_count=0; out_data undefined-but-stable (memory not cleared). Array contents not reset.

## Timing
- Write latency: rx_done at edge N -> out_valid=1, level updated after edge N (visible in cycle N+1).
- out_data = mem[rd_ptr] combinationally from the array; changes the cycle after a read event.
- Read throughput one byte/cycle; write throughput one byte/cycle (receiver produces far slower).
- full, level, out_valid all derive from the registered count; no combinational path from rx_done or out_ready to any output except through registers (out_data depends on rd_ptr only).
- Simultaneous write and read at count==0 is impossible; write into empty FIFO is never bypassed to out_data in the same cycle.

## Configuration
- UART_RX_FIFO_DROP_ERR_EN defined: bytes arriving with rx_error=1 are not stored (no pointer/count change, cannot cause overflow); err_count still increments.
- Not defined: errored bytes are stored like any other byte; err_count still increments.

## Test plan
- Reset then write 0xA5 via rx_done -> next cycle out_valid=1, out_data=0xA5, level=1; pulse out_ready -> out_valid=0, level=0.
- Write 16 bytes 0x00..0x0F with out_ready=0 -> full=1, level=16; 17th byte 0x55 -> dropped, overflow=1; drain -> 0x00..0x0F in order, then 0x55 absent.
- At full, rx_done 0x77 with out_ready=1 same cycle -> level stays 16, last byte read out is 0x77, overflow stays 0.
- rx_done 0x3C with rx_error=1 -> err_count=1; with macro level=0, without macro level=1 and out_data=0x3C; 300 errored strobes -> err_count=255.
- Fill 5 bytes, assert clear with concurrent rx_done 0x11 -> level=0, overflow=0, err_count=0, out_valid=0.
- Wrap-around: 40 writes interleaved with reads, level oscillating 0..3 -> output sequence matches input exactly; assert reset_n=0 mid-sequence -> all outputs at reset values next cycle, subsequent byte 0x99 read correctly.
